// File: rtl/ss_xfifo_if.sv
// rtl/ss_xfifo_if.sv - read/write SG engine handshake bundle for ss_xfifo
interface ss_xfifo_if;
    logic        r_xfer;
    logic        r_last;
    logic [63:0] r_dat;
    logic        r_start;
    logic        r_stop;
    logic        r_end;
    logic        w_xfer;
    logic [63:0] w_dat;
    logic        w_start;
    logic        w_stop;
    logic        w_end;

    modport master (
        output r_xfer, r_last, r_dat, w_xfer,
        input  r_start, r_stop, r_end, w_dat, w_start, w_stop, w_end
    );

    modport slave (
        input  r_xfer, r_last, r_dat, w_xfer,
        output r_start, r_stop, r_end, w_dat, w_start, w_stop, w_end
    );
endinterface

// File: rtl/ss_xfifo.sv
// rtl/ss_xfifo.sv - ADMA channel buffer and read/write SG flow controller
module ss_xfifo #(
    parameter int AW     = 4,
    parameter int RSTART = 8,
    parameter int WSTART = 4
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          go,
    input  logic          clear,
    ss_xfifo_if.slave     bus,
    output logic [AW:0]   count,
    output logic [1:0]    err,
    output logic          x_done
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_V  = (AW+1)'(DEPTH);
    localparam logic [AW:0] DEPTH_M1 = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] RSTART_V = (AW+1)'(RSTART);
    localparam logic [AW:0] WSTART_V = (AW+1)'(WSTART);
    localparam logic [AW:0] ONE_V    = (AW+1)'(1);
    localparam logic [AW:0] ZERO_V   = '0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        DRAIN = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          last_seen_q, last_seen_d;
    logic [1:0]    err_q, err_d;
    logic          mem_we;

    logic [63:0]   mem [DEPTH];

    logic          is_fill, is_drain, is_err;
    logic          push, marker, pop, ovf, udf;
    logic [AW:0]   free_cnt;

    assign is_fill  = (state_q == FILL);
    assign is_drain = (state_q == DRAIN);
    assign is_err   = (state_q == ERR);
    assign push     = is_fill & bus.r_xfer & ~bus.r_last;
    assign marker   = is_fill & bus.r_xfer & bus.r_last;
    assign pop      = (is_fill | is_drain) & bus.w_xfer;
    assign ovf      = push & ~pop & (count_q == DEPTH_V);
    assign udf      = pop & ~push & (count_q == ZERO_V);
    assign free_cnt = DEPTH_V - count_q;

    // Next-state, pointer, occupancy and error-flag computation
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        last_seen_d = last_seen_q;
        err_d       = err_q;
        mem_we      = 1'b0;
        if (clear) begin
            state_d     = IDLE;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            last_seen_d = 1'b0;
            err_d       = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go) begin
                        state_d     = FILL;
                        wr_ptr_d    = '0;
                        rd_ptr_d    = '0;
                        count_d     = '0;
                        last_seen_d = 1'b0;
                    end
                end
                FILL, DRAIN: begin
                    if (ovf) begin
                        err_d[0] = 1'b1;
                        state_d  = ERR;
                    end else if (udf) begin
                        err_d[1] = 1'b1;
                        state_d  = ERR;
                    end else begin
                        if (push) begin
                            mem_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + AW'(1);
                        end
                        if (pop) begin
                            rd_ptr_d = rd_ptr_q + AW'(1);
                        end
                        case ({push, pop})
                            2'b10:   count_d = count_q + ONE_V;
                            2'b01:   count_d = count_q - ONE_V;
                            default: count_d = count_q;
                        endcase
                        if (marker) begin
                            last_seen_d = 1'b1;
                            state_d     = DRAIN;
                        end
                        if (is_drain && ((count_q == ZERO_V) || (count_q == ONE_V && pop))) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE, ERR: state_d = state_q;
                default:   state_d = IDLE;
            endcase
        end
    end

    // State and bookkeeping registers with asynchronous reset
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            last_seen_q <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            last_seen_q <= last_seen_d;
            err_q       <= err_d;
        end
    end

    // Beat storage; contents survive reset, only pointers are cleared
    always_ff @(posedge wb_clk_i) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= bus.r_dat;
        end
    end

    // Flow signals are decoded from registered state so SG engines can sample them on the ack
    assign bus.r_start = is_fill & (free_cnt >= RSTART_V);
    assign bus.r_stop  = (is_fill & (count_q >= DEPTH_M1)) | is_err;
    assign bus.w_start = (is_fill & (count_q >= WSTART_V))
                       | (is_drain & last_seen_q & (count_q != ZERO_V));
    assign bus.w_stop  = ((is_fill | is_drain) & (count_q <= ONE_V)
                          & ~(is_drain & (count_q == ZERO_V))) | is_err;
    assign bus.r_end   = is_drain | (state_q == DONE);
    assign bus.w_end   = (state_q == DONE);
    assign bus.w_dat   = mem[rd_ptr_q];

    assign count  = count_q;
    assign err    = err_q;
    assign x_done = (state_q == IDLE) | (state_q == DONE);
endmodule

// File: tb/tb_ss_xfifo.sv
// tb/tb_ss_xfifo.sv - scoreboard bench for ss_xfifo
module tb_ss_xfifo;
    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        go;
    logic        clear;
    logic [4:0]  count;
    logic [1:0]  err;
    logic        x_done;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];

    ss_xfifo_if bus ();

    ss_xfifo #(.AW(4), .RSTART(8), .WSTART(4)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .go       (go),
        .clear    (clear),
        .bus      (bus),
        .count    (count),
        .err      (err),
        .x_done   (x_done)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic cycle();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic do_go();
        go = 1'b1;
        cycle();
        go = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    task automatic do_push(input logic [63:0] d, input bit track);
        bus.r_xfer = 1'b1;
        bus.r_last = 1'b0;
        bus.r_dat  = d;
        if (track) sb.push_back(d);
        cycle();
        bus.r_xfer = 1'b0;
    endtask

    task automatic do_marker();
        bus.r_xfer = 1'b1;
        bus.r_last = 1'b1;
        cycle();
        bus.r_xfer = 1'b0;
        bus.r_last = 1'b0;
    endtask

    task automatic do_pop(output logic [63:0] d);
        d = bus.w_dat;
        bus.w_xfer = 1'b1;
        cycle();
        bus.w_xfer = 1'b0;
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        repeat (2) cycle();
        checks++; if (count !== 5'd0)  begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
        checks++; if (err !== 2'b00)   begin errors++; $display("FAIL rst_err got %b exp 00", err); end
        checks++; if (x_done !== 1'b1) begin errors++; $display("FAIL rst_x_done got %b exp 1", x_done); end
        checks++; if ({bus.r_start, bus.r_stop, bus.w_start, bus.w_stop, bus.r_end, bus.w_end} !== 6'b0)
            begin errors++; $display("FAIL rst_flow got %b exp 000000",
                {bus.r_start, bus.r_stop, bus.w_start, bus.w_stop, bus.r_end, bus.w_end}); end
        wb_rst_i = 1'b0;
        cycle();
        do_go();
        for (int i = 0; i < 5; i++) do_push(64'(100 + i), 1'b0);
        checks++; if (count !== 5'd5) begin errors++; $display("FAIL midfill_count got %0d exp 5", count); end
        #2 wb_rst_i = 1'b1;
        #1;
        checks++; if (count !== 5'd0)    begin errors++; $display("FAIL async_rst_count got %0d exp 0", count); end
        checks++; if (x_done !== 1'b1)   begin errors++; $display("FAIL async_rst_x_done got %b exp 1", x_done); end
        checks++; if (bus.r_start !== 1'b0) begin errors++; $display("FAIL async_rst_r_start got %b exp 0", bus.r_start); end
        cycle();
        wb_rst_i = 1'b0;
        cycle();
    endtask

    task automatic test_fill();
        logic e_start, e_stop;
        do_go();
        checks++; if (bus.r_start !== 1'b1) begin errors++; $display("FAIL go_r_start got %b exp 1", bus.r_start); end
        for (int k = 1; k <= 16; k++) begin
            do_push(64'(k), 1'b1);
            e_start = (k <= 8);
            e_stop  = (k >= 15);
            checks++; if (count !== 5'(k)) begin errors++; $display("FAIL fill_count k=%0d got %0d exp %0d", k, count, k); end
            checks++; if (bus.r_start !== e_start) begin errors++; $display("FAIL fill_r_start k=%0d got %b exp %b", k, bus.r_start, e_start); end
            checks++; if (bus.r_stop !== e_stop) begin errors++; $display("FAIL fill_r_stop k=%0d got %b exp %b", k, bus.r_stop, e_stop); end
            checks++; if (bus.w_dat !== 64'h1) begin errors++; $display("FAIL fill_w_dat k=%0d got %h exp 1", k, bus.w_dat); end
        end
    endtask

    task automatic test_full_push_pop();
        logic [63:0] d, e;
        bus.r_xfer = 1'b1;
        bus.r_last = 1'b0;
        bus.r_dat  = 64'h11;
        sb.push_back(64'h11);
        do_pop(d);
        bus.r_xfer = 1'b0;
        e = sb.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL pp_pop_data got %h exp %h", d, e); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL pp_count got %0d exp 16", count); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL pp_err got %b exp 00", err); end
        checks++; if (bus.w_dat !== 64'h2) begin errors++; $display("FAIL pp_w_dat got %h exp 2", bus.w_dat); end
        for (int i = 0; i < 16; i++) begin
            do_pop(d);
            e = sb.pop_front();
            checks++; if (d !== e) begin errors++; $display("FAIL drain_data i=%0d got %h exp %h", i, d, e); end
        end
        checks++; if (count !== 5'd0 || x_done !== 1'b0 || err !== 2'b00)
            begin errors++; $display("FAIL drained_state got count=%0d x_done=%b err=%b exp 0 0 00", count, x_done, err); end
        do_clear();
    endtask

    task automatic test_marker_drain();
        logic [63:0] d, e;
        do_go();
        for (int i = 0; i < 3; i++) do_push(64'hA0 + 64'(i), 1'b1);
        do_marker();
        checks++; if (bus.r_end !== 1'b1)   begin errors++; $display("FAIL mk_r_end got %b exp 1", bus.r_end); end
        checks++; if (bus.w_start !== 1'b1) begin errors++; $display("FAIL mk_w_start got %b exp 1", bus.w_start); end
        checks++; if (bus.r_start !== 1'b0 || bus.w_end !== 1'b0 || x_done !== 1'b0)
            begin errors++; $display("FAIL mk_flags got r_start=%b w_end=%b x_done=%b exp 0 0 0", bus.r_start, bus.w_end, x_done); end
        checks++; if (count !== 5'd3) begin errors++; $display("FAIL mk_count got %0d exp 3", count); end
        for (int i = 0; i < 3; i++) begin
            do_pop(d);
            e = sb.pop_front();
            checks++; if (d !== e) begin errors++; $display("FAIL mk_pop i=%0d got %h exp %h", i, d, e); end
        end
        checks++; if (bus.w_end !== 1'b1 || x_done !== 1'b1 || count !== 5'd0)
            begin errors++; $display("FAIL done_state got w_end=%b x_done=%b count=%0d exp 1 1 0", bus.w_end, x_done, count); end
        do_clear();
        checks++; if (bus.w_end !== 1'b0 || bus.r_end !== 1'b0 || x_done !== 1'b1)
            begin errors++; $display("FAIL clr_idle got w_end=%b r_end=%b x_done=%b exp 0 0 1", bus.w_end, bus.r_end, x_done); end
    endtask

    task automatic test_overflow();
        do_go();
        for (int i = 0; i < 16; i++) do_push(64'h200 + 64'(i), 1'b0);
        do_push(64'hDEAD, 1'b0);
        checks++; if (err !== 2'b01) begin errors++; $display("FAIL ovf_err got %b exp 01", err); end
        checks++; if (bus.r_stop !== 1'b1 || bus.w_stop !== 1'b1)
            begin errors++; $display("FAIL ovf_stops got r_stop=%b w_stop=%b exp 1 1", bus.r_stop, bus.w_stop); end
        checks++; if (bus.r_start !== 1'b0 || bus.w_start !== 1'b0 || x_done !== 1'b0)
            begin errors++; $display("FAIL ovf_flags got r_start=%b w_start=%b x_done=%b exp 0 0 0", bus.r_start, bus.w_start, x_done); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d exp 16", count); end
        checks++; if (bus.w_dat !== 64'h200) begin errors++; $display("FAIL ovf_head got %h exp 200", bus.w_dat); end
        do_clear();
        checks++; if (err !== 2'b00 || count !== 5'd0 || x_done !== 1'b1)
            begin errors++; $display("FAIL ovf_clear got err=%b count=%0d x_done=%b exp 00 0 1", err, count, x_done); end
    endtask

    task automatic test_underflow_and_clear_go();
        logic [63:0] d;
        do_go();
        do_pop(d);
        checks++; if (err !== 2'b10) begin errors++; $display("FAIL udf_err got %b exp 10", err); end
        checks++; if (bus.w_stop !== 1'b1 || bus.r_stop !== 1'b1 || x_done !== 1'b0)
            begin errors++; $display("FAIL udf_flags got w_stop=%b r_stop=%b x_done=%b exp 1 1 0", bus.w_stop, bus.r_stop, x_done); end
        do_clear();
        do_go();
        do_marker();
        checks++; if (bus.r_end !== 1'b1 || bus.w_start !== 1'b0 || bus.w_stop !== 1'b0)
            begin errors++; $display("FAIL empty_drain got r_end=%b w_start=%b w_stop=%b exp 1 0 0", bus.r_end, bus.w_start, bus.w_stop); end
        cycle();
        checks++; if (bus.w_end !== 1'b1) begin errors++; $display("FAIL empty_done got w_end=%b exp 1", bus.w_end); end
        clear = 1'b1;
        go    = 1'b1;
        cycle();
        clear = 1'b0;
        go    = 1'b0;
        checks++; if (x_done !== 1'b1 || bus.r_start !== 1'b0 || bus.w_end !== 1'b0 || bus.r_end !== 1'b0)
            begin errors++; $display("FAIL clr_go got x_done=%b r_start=%b w_end=%b r_end=%b exp 1 0 0 0",
                x_done, bus.r_start, bus.w_end, bus.r_end); end
    endtask

    initial begin
        go         = 1'b0;
        clear      = 1'b0;
        wb_rst_i   = 1'b1;
        bus.r_xfer = 1'b0;
        bus.r_last = 1'b0;
        bus.r_dat  = '0;
        bus.w_xfer = 1'b0;
        test_reset();
        test_fill();
        test_full_push_pop();
        test_marker_drain();
        test_overflow();
        test_underflow_and_clear_go();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
